spi_reg_bank: RTL

Parametrised SPI register-bank peripheral; successor to the fixed 5-register, write-only SPI config block. Samples an external mode-0 SPI bus (SCLK, nCS, COPI) in the system clock domain and supports burst writes with address auto-increment. Adds read-back over CIPO and per-register write strobes. Feeds the output-enable, PWM-enable and duty-cycle registers of the top level, and any future register consumers.

---
 rtl/spi_reg_bank_if.sv | 19 +
 rtl/spi_reg_bank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: SPI pins between a controller and the register bank.
// Controller drives SCLK/nCS/COPI; the bank returns CIPO and its pad enable.
interface spi_reg_bank_if;
  logic SCLK;
  logic nCS;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (
    output SCLK, nCS, COPI,
    input  CIPO, cipo_oe
  );

  modport slave (
    input  SCLK, nCS, COPI,
    output CIPO, cipo_oe
  );
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: mode-0 SPI register bank, burst writes with auto-increment.
// Read-back over CIPO exists only when SPI_REG_READ_EN is defined.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);
  localparam int MW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW = $clog2(MW) + 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    ADDR,
    DATA
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sy, ncs_sy, copi_sy, live_sy;
  logic sclk_q, ncs_q, armed;
  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, ncs_fall, ncs_rise;
  logic addr_done, word_done, err_nxt;
  logic is_wr;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-2:0] sh_in;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] regs [NUM_REGS];

  assign sclk_s = sclk_sy[SYNC_STAGES-1];
  assign ncs_s  = ncs_sy[SYNC_STAGES-1];
  assign copi_s = copi_sy[SYNC_STAGES-1];

  // SCLK activity only counts while the synced chip select is low.
  assign sclk_rise = sclk_s & ~sclk_q & ~ncs_s;
  // armed blocks a frame start from an nCS that was already low at reset release.
  assign ncs_fall  = armed & ncs_q & ~ncs_s;
  assign ncs_rise  = ~ncs_q & ncs_s;

  assign addr_nxt  = {addr[ADDR_W-2:0], copi_s};
  assign word      = {sh_in, copi_s};
  assign addr_done = (state == ADDR) & sclk_rise & (cnt == ADDR_LAST);
  assign word_done = (state == DATA) & sclk_rise & (cnt == DATA_LAST);

  // Synchronisers, edge history and post-reset arming of nCS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sy <= '0;
      ncs_sy  <= '1;
      copi_sy <= '0;
      live_sy <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      armed   <= 1'b0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], spi.SCLK};
      ncs_sy  <= {ncs_sy[SYNC_STAGES-2:0], spi.nCS};
      copi_sy <= {copi_sy[SYNC_STAGES-2:0], spi.COPI};
      live_sy <= {live_sy[SYNC_STAGES-2:0], 1'b1};
      sclk_q  <= sclk_s;
      ncs_q   <= ncs_s;
      armed   <= armed | (live_sy[SYNC_STAGES-1] & ncs_s);
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; an early nCS release flags a broken frame.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE:    if (ncs_fall) state_nxt = CMD;
      CMD:     if (sclk_rise) state_nxt = ADDR;
      ADDR:    if (addr_done) state_nxt = DATA;
      DATA:    state_nxt = DATA;
      default: state_nxt = IDLE;
    endcase
    if (ncs_rise && state != IDLE) begin
      state_nxt = IDLE;
      err_nxt   = (state != DATA) || (cnt != '0);
    end
  end

  // Bit counting, address/data shifting and register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr      <= '0;
      sh_in     <= '0;
      is_wr     <= 1'b0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= '0;
      frame_err <= err_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (word_done)     cnt <= '0;
      else if (sclk_rise)     cnt <= cnt + CW'(1);
      if (state == CMD && sclk_rise)  is_wr <= copi_s;
      if (state == ADDR && sclk_rise) addr  <= addr_nxt;
      if (state == DATA && sclk_rise) sh_in <= word[DATA_W-2:0];
      if (word_done) begin
        addr <= addr + ADDR_W'(1);
        for (int i = 0; i < NUM_REGS; i++) begin
          if (is_wr && addr == ADDR_W'(i)) begin
            regs[i]      <= word;
            wr_strobe[i] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

`ifdef SPI_REG_READ_EN
  logic sclk_fall;
  logic cipo_q;
  logic [DATA_W-1:0] rd_sh;

  assign sclk_fall = ~sclk_s & sclk_q & ~ncs_s;

  function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
    reg_at = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) reg_at = regs[i];
  endfunction

  // Read shifter: load on address/word completion, shift out on falling SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sh  <= '0;
      cipo_q <= 1'b0;
    end else if (state == IDLE) begin
      cipo_q <= 1'b0;
    end else if (!is_wr) begin
      if (addr_done) begin
        rd_sh <= reg_at(addr_nxt);
      end else if (word_done) begin
        rd_sh <= reg_at(addr + ADDR_W'(1));
      end else if (state == DATA && sclk_fall) begin
        cipo_q <= rd_sh[DATA_W-1];
        rd_sh  <= {rd_sh[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign spi.cipo_oe = (state == DATA) & ~is_wr;
  assign spi.CIPO    = spi.cipo_oe & cipo_q;
`else
  assign spi.cipo_oe = 1'b0;
  assign spi.CIPO    = 1'b0;
`endif
endmodule
